// File: rtl/axil_ram_bist_pkg.sv
// Shared types and AXI response codes for the AXI4-Lite RAM self-test master.
package axil_ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_DATA,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_ram_bist_pattern.sv
// Pattern source for the RAM self-test: registered word address and index,
// combinational data word seed+k. Rewound between the write and read phases.
module axil_ram_bist_pattern #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int LEN_WIDTH  = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  rewind,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic [LEN_WIDTH-1:0]  idx
);

    logic [ADDR_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [ADDR_WIDTH-1:0] base_aligned;

    assign base_aligned = base & ~ADDR_WIDTH'(STRB_WIDTH-1);
    assign data         = seed_q + DATA_WIDTH'(idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q <= '0;
            seed_q <= '0;
            addr   <= '0;
            idx    <= '0;
        end else if (load) begin
            base_q <= base_aligned;
            seed_q <= seed;
            addr   <= base_aligned;
            idx    <= '0;
        end else if (rewind) begin
            addr <= base_q;
            idx  <= '0;
        end else if (step) begin
            // address wraps naturally at the top of the byte address space
            addr <= addr + ADDR_WIDTH'(STRB_WIDTH);
            idx  <= idx + LEN_WIDTH'(1);
        end
    end

endmodule

// File: rtl/axil_ram_bist.sv
// AXI4-Lite master that writes seed+k over a word range, reads it back and
// reports pass/fail. Optional AXIL_RAM_BIST_ERR_COUNT_EN adds an error counter.
module axil_ram_bist
    import axil_ram_bist_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int LEN_WIDTH  = ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] err_addr,
`ifdef AXIL_RAM_BIST_ERR_COUNT_EN
    output logic [LEN_WIDTH-1:0]  err_count,
`endif
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  err_flag;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [LEN_WIDTH-1:0]  idx;
    logic                  last, load, rewind, step, b_hs, r_hs, miss;

    assign last   = (idx == len_q - LEN_WIDTH'(1));
    assign load   = (state == IDLE) && start;
    assign b_hs   = m_axil_bvalid && m_axil_bready;
    assign r_hs   = m_axil_rvalid && m_axil_rready;
    assign rewind = b_hs && last;
    assign step   = (b_hs || r_hs) && !last;
    assign miss   = (b_hs && (m_axil_bresp != RESP_OKAY)) ||
                    (r_hs && ((m_axil_rdata != data) || (m_axil_rresp != RESP_OKAY)));

    assign m_axil_awaddr = addr;
    assign m_axil_araddr = addr;
    assign m_axil_wdata  = data;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;
    assign m_axil_wstrb  = '1;

    axil_ram_bist_pattern #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .STRB_WIDTH(STRB_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_pattern (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .rewind(rewind),
        .step  (step),
        .base  (cfg_base),
        .seed  (cfg_seed),
        .addr  (addr),
        .data  (data),
        .idx   (idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_addr       <= '0;
            err_flag       <= 1'b0;
            len_q          <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else begin
            done <= 1'b0;
            // only the first failure of a run is located
            if (miss) begin
                if (!err_flag) err_addr <= addr;
                err_flag <= 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    busy     <= 1'b1;
                    pass     <= 1'b0;
                    err_flag <= 1'b0;
                    len_q    <= cfg_len;
                    if (cfg_len == '0) begin
                        state <= DONE;
                    end else begin
                        state          <= WR;
                        m_axil_awvalid <= 1'b1;
                        m_axil_wvalid  <= 1'b1;
                    end
                end
                WR: begin
                    if (m_axil_awready) m_axil_awvalid <= 1'b0;
                    if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
                    if ((!m_axil_awvalid || m_axil_awready) &&
                        (!m_axil_wvalid  || m_axil_wready)) begin
                        state         <= WR_RESP;
                        m_axil_bready <= 1'b1;
                    end
                end
                WR_RESP: if (m_axil_bvalid) begin
                    m_axil_bready <= 1'b0;
                    if (last) begin
                        state          <= RD;
                        m_axil_arvalid <= 1'b1;
                    end else begin
                        state          <= WR;
                        m_axil_awvalid <= 1'b1;
                        m_axil_wvalid  <= 1'b1;
                    end
                end
                RD: if (m_axil_arready) begin
                    state          <= RD_DATA;
                    m_axil_arvalid <= 1'b0;
                    m_axil_rready  <= 1'b1;
                end
                RD_DATA: if (m_axil_rvalid) begin
                    m_axil_rready <= 1'b0;
                    if (last) begin
                        state <= DONE;
                    end else begin
                        state          <= RD;
                        m_axil_arvalid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    pass  <= !err_flag;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIL_RAM_BIST_ERR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (load) begin
            err_count <= '0;
        end else if (miss && (err_count != '1)) begin
            err_count <= err_count + LEN_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_axil_ram_bist.sv
// Bench for axil_ram_bist: AXI4-Lite RAM slave with stall/fault knobs and a
// reference model of the expected address order, data and error outcome.
module tb_axil_ram_bist;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic [LW-1:0] cfg_len = '0;
    logic [DW-1:0] cfg_seed = '0;
    logic          busy, done, pass;
    logic [AW-1:0] err_addr;
`ifdef AXIL_RAM_BIST_ERR_COUNT_EN
    logic [LW-1:0] err_count;
`endif
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axil_ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_seed(cfg_seed),
        .busy(busy), .done(done), .pass(pass), .err_addr(err_addr),
`ifdef AXIL_RAM_BIST_ERR_COUNT_EN
        .err_count(err_count),
`endif
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    // slave knobs
    int            aw_stall = 0, w_stall = 0, r_gap_max = 0;
    logic          flip_en = 1'b0, berr_en = 1'b0;
    logic [AW-1:0] flip_a0 = '0, flip_a1 = '0, berr_a = '0;

    logic [DW-1:0] mem [0:(1<<(AW-2))-1];
    logic [AW-1:0] wr_log[$];
    logic [AW-1:0] rd_log[$];
    logic          aw_have, w_have, r_have;
    logic [AW-1:0] aw_q, ar_q;
    logic [DW-1:0] w_q;
    int            aw_cnt, w_cnt, r_wait;

    assign awready = awvalid && !aw_have && !bvalid && (aw_cnt >= aw_stall);
    assign wready  = wvalid && !w_have && !bvalid && (w_cnt >= w_stall);
    assign arready = arvalid && !r_have && !rvalid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_have <= 1'b0; w_have <= 1'b0; r_have <= 1'b0;
            bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
            aw_q <= '0; w_q <= '0; ar_q <= '0; aw_cnt <= 0; w_cnt <= 0; r_wait <= 0;
        end else begin
            if (awvalid && awready) begin
                aw_have <= 1'b1; aw_q <= awaddr; aw_cnt <= 0; wr_log.push_back(awaddr);
            end else if (awvalid && !aw_have) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                w_have <= 1'b1; w_q <= wdata; w_cnt <= 0;
            end else if (wvalid && !w_have) begin
                w_cnt <= w_cnt + 1;
            end
            if (aw_have && w_have) begin
                mem[aw_q[AW-1:2]] <= w_q;
                bvalid  <= 1'b1;
                bresp   <= (berr_en && aw_q == berr_a) ? 2'b10 : 2'b00;
                aw_have <= 1'b0;
                w_have  <= 1'b0;
            end
            if (bvalid && bready) bvalid <= 1'b0;
            if (arvalid && arready) begin
                r_have <= 1'b1; ar_q <= araddr; rd_log.push_back(araddr);
                r_wait <= int'($urandom_range(r_gap_max, 0));
            end
            if (r_have) begin
                if (r_wait == 0) begin
                    rvalid <= 1'b1;
                    rresp  <= 2'b00;
                    rdata  <= mem[ar_q[AW-1:2]] ^
                              ((flip_en && (ar_q == flip_a0 || ar_q == flip_a1)) ? 32'h1 : 32'h0);
                    r_have <= 1'b0;
                end else begin
                    r_wait <= r_wait - 1;
                end
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // handshake-stability monitor and done-pulse counter
    int            proto_err = 0, done_cnt = 0;
    logic          awp, wp, arp;
    logic [AW-1:0] awa_p, ara_p;
    logic [DW-1:0] wd_p;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            awp <= 1'b0; wp <= 1'b0; arp <= 1'b0; awa_p <= '0; ara_p <= '0; wd_p <= '0;
        end else begin
            if (awp && (!awvalid || awaddr != awa_p)) proto_err <= proto_err + 1;
            if (wp && (!wvalid || wdata != wd_p))     proto_err <= proto_err + 1;
            if (arp && (!arvalid || araddr != ara_p)) proto_err <= proto_err + 1;
            awp <= awvalid && !awready; awa_p <= awaddr;
            wp  <= wvalid && !wready;   wd_p  <= wdata;
            arp <= arvalid && !arready; ara_p <= araddr;
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic full_test(input string tag, input logic [AW-1:0] base, input logic [LW-1:0] len,
                             input logic [DW-1:0] seed, input bit poke);
        int wr0, rd0, d0, p0, cycles, wbad, rbad, mbad, nerr;
        logic [AW-1:0] a, first_ea;
        wr0 = wr_log.size(); rd0 = rd_log.size(); d0 = done_cnt; p0 = proto_err;
        @(negedge clk);
        cfg_base = base; cfg_len = len; cfg_seed = seed; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cycles = 0;
        while (done !== 1'b1 && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            start = poke && cycles == 4;
            if (start) begin cfg_len = 3; cfg_seed = ~seed; cfg_base = base + 16'h0040; end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, cycles < 5000, 1'b1);
        // reference: address k = aligned base + 4k (mod 2^16), data seed+k,
        // write-phase faults precede read-phase faults
        wbad = 0; rbad = 0; mbad = 0; nerr = 0; first_ea = '0;
        for (int k = 0; k < int'(len); k++) begin
            a = (base & 16'hFFFC) + 16'(k * SW);
            if (wr0 + k >= wr_log.size() || wr_log[wr0 + k] !== a) wbad++;
            if (rd0 + k >= rd_log.size() || rd_log[rd0 + k] !== a) rbad++;
            if (mem[a[AW-1:2]] !== seed + DW'(k)) mbad++;
            if (berr_en && a == berr_a) begin if (nerr == 0) first_ea = a; nerr++; end
        end
        for (int k = 0; k < int'(len); k++) begin
            a = (base & 16'hFFFC) + 16'(k * SW);
            if (flip_en && (a == flip_a0 || a == flip_a1)) begin if (nerr == 0) first_ea = a; nerr++; end
        end
        chk({tag, "_wr_count"}, wr_log.size() - wr0, len);
        chk({tag, "_rd_count"}, rd_log.size() - rd0, len);
        chk({tag, "_wr_order"}, wbad, 0);
        chk({tag, "_rd_order"}, rbad, 0);
        chk({tag, "_mem"}, mbad, 0);
        chk({tag, "_pass"}, pass, nerr == 0);
        if (nerr != 0) chk({tag, "_err_addr"}, err_addr, first_ea);
`ifdef AXIL_RAM_BIST_ERR_COUNT_EN
        chk({tag, "_err_count"}, err_count, nerr);
`endif
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_proto"}, proto_err - p0, 0);
        if (len == 0) chk({tag, "_len0_latency"}, cycles, 1);
    endtask

    initial begin
        int cycles;
        logic [AW-1:0] probe;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err_addr", err_addr, 16'h0000);
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("const_prot_strb", {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'hF});
        rst = 1'b0;
        @(negedge clk);

        full_test("basic", 16'h0100, 16, 32'hA5A50000, 1'b0);
        probe = 16'h0104;
        chk("basic_word_0104", mem[probe[AW-1:2]], 32'hA5A50001);

        flip_en = 1'b1; flip_a0 = 16'h0108; flip_a1 = 16'h0110;
        full_test("flip", 16'h0100, 16, 32'hA5A50000, 1'b0);
        flip_en = 1'b0;

        berr_en = 1'b1; berr_a = 16'h0308;
        full_test("bresp", 16'h0300, 6, 32'h0000_1000, 1'b0);
        berr_en = 1'b0;

        aw_stall = 3; w_stall = 1; r_gap_max = 3;
        full_test("stall", 16'h0400, 12, 32'hFFFF_FFFA, 1'b0);

        aw_stall = 0; w_stall = 0; r_gap_max = 0;
        full_test("wrap", 16'hFFF8, 4, 32'h1111_0000, 1'b0);
        chk("wrap_third_addr", rd_log[rd_log.size() - 2], 16'h0000);

        full_test("len0", 16'h0500, 0, 32'h0, 1'b0);
        full_test("busy_start", 16'h0600, 16, 32'h5555_0000, 1'b1);

        for (int i = 0; i < 4; i++) begin
            aw_stall = int'($urandom_range(3, 0)); w_stall = int'($urandom_range(3, 0));
            r_gap_max = int'($urandom_range(3, 0));
            full_test("rand", AW'($urandom), LW'($urandom_range(24, 1)), $urandom, 1'b0);
        end

        // asynchronous reset while a write is outstanding
        aw_stall = 3; w_stall = 1; r_gap_max = 0;
        @(negedge clk);
        cfg_base = 16'h0200; cfg_len = 8; cfg_seed = 32'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cycles = 0;
        while (awvalid !== 1'b1 && cycles < 50) begin @(negedge clk); cycles++; end
        chk("rst_mid_wr_seen", awvalid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_valids", {awvalid, wvalid}, 2'b00);
        chk("rst_mid_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        aw_stall = 0; w_stall = 0;
        full_test("after_rst", 16'h0200, 8, 32'h0BAD_F00D, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
